// File: rtl/usb_da_buffer.sv
// usb_da_buffer: captures FX3 slave-FIFO words into a single-clock FIFO and
// unpacks each word into two 14-bit DAC samples at a fixed rate.
// state   | meaning
// ST_LOW  | next sample is head[15:2]
// ST_HIGH | next sample is head[31:18]; issuing it pops the head word
module usb_da_buffer #(
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 2,
  parameter int DIV          = 4,
  parameter int AFULL_MARGIN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DATA_DIR,
  input  logic              SLCS,
  input  logic              SLOE,
  input  logic              SLRD,
  input  logic [31:0]       DQ,
  input  logic              dac_en,
  output logic [13:0]       dac_data,
  output logic              dac_valid,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_afull,
  output logic              overflow,
  output logic              underrun,
  output logic [15:0]       drop_cnt
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [7:0]        CNT_LAST   = 8'(DIV - 1);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } unpack_state_e;

  // Capture pipeline: strobe qualifier delayed to line up with DQ
  logic              rd_qual;
  logic [RD_LAT-1:0] rd_sr_q, rd_sr_d;
  logic              wr_req;

  assign rd_qual = ~SLCS & ~SLOE & ~SLRD & ~DATA_DIR;

  always_comb begin
    rd_sr_d = RD_LAT'({rd_sr_q, rd_qual});
    if (DATA_DIR) rd_sr_d = '0;
  end

  assign wr_req = rd_sr_q[RD_LAT-1] & ~DATA_DIR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sr_q <= '0;
    else        rd_sr_q <= rd_sr_d;
  end

  // Only the sample-bearing bits are stored
  logic [27:0] wr_word;
  logic [3:0]  dq_unused;
  assign wr_word   = {DQ[31:18], DQ[15:2]};
  assign dq_unused = {DQ[17:16], DQ[1:0]};

  // FIFO
  logic [27:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [27:0]       rd_word_q, rd_word_d;
  logic              push, pop, drop, fifo_empty;
  logic              afull_q, afull_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  assign fifo_empty = (level_q == '0);
  // A pop in the same cycle frees a slot, so a write into a full FIFO is kept
  assign push = wr_req & ((level_q != LEVEL_FULL) | pop);
  assign drop = wr_req & (level_q == LEVEL_FULL) & ~pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    // Registered head read, bypassing the word being written into the head slot
    rd_word_d  = (push && (wr_ptr_q == rd_ptr_d)) ? wr_word : mem[rd_ptr_d];
    afull_d    = (32'(LEVEL_FULL - level_q) <= AFULL_MARGIN);
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_word_q  <= '0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_word_q  <= rd_word_d;
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Sample-rate counter
  logic [7:0] cnt_q, cnt_d;
  logic       tick;

  assign tick = dac_en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!dac_en || tick) cnt_d = '0;
  end

  // Unpacker FSM
  unpack_state_e state_q, state_d;
  logic [13:0]   dac_data_q, dac_data_d;
  logic          dac_valid_q, dac_valid_d;
  logic          underrun_q, underrun_d;

  always_comb begin
    state_d     = state_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    underrun_d  = underrun_q;
    pop         = 1'b0;
    if (tick) begin
      if (fifo_empty) begin
        underrun_d = 1'b1;
      end else begin
        dac_valid_d = 1'b1;
        case (state_q)
          ST_LOW: begin
            dac_data_d = rd_word_q[13:0];
            state_d    = ST_HIGH;
          end
          ST_HIGH: begin
            dac_data_d = rd_word_q[27:14];
            state_d    = ST_LOW;
            pop        = 1'b1;
          end
          default: state_d = ST_LOW;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= ST_LOW;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign fifo_level = level_q;
  assign fifo_afull = afull_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_usb_da_buffer.sv
// Directed bench for usb_da_buffer: 16-word FIFO, RD_LAT=2, DIV=4, afull margin 4.
module tb_usb_da_buffer;

  logic        clk;
  logic        rst_n;
  logic        DATA_DIR, SLCS, SLOE, SLRD;
  logic [31:0] DQ;
  logic        dac_en;
  logic [13:0] dac_data;
  logic        dac_valid;
  logic [4:0]  fifo_level;
  logic        fifo_afull, overflow, underrun;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  usb_da_buffer #(
    .ADDR_W(4), .RD_LAT(2), .DIV(4), .AFULL_MARGIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DATA_DIR(DATA_DIR), .SLCS(SLCS), .SLOE(SLOE),
    .SLRD(SLRD), .DQ(DQ), .dac_en(dac_en), .dac_data(dac_data),
    .dac_valid(dac_valid), .fifo_level(fifo_level), .fifo_afull(fifo_afull),
    .overflow(overflow), .underrun(underrun), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dac_data"},   32'(dac_data),   32'h0);
    chk({tag, " dac_valid"},  32'(dac_valid),  32'h0);
    chk({tag, " fifo_level"}, 32'(fifo_level), 32'h0);
    chk({tag, " fifo_afull"}, 32'(fifo_afull), 32'h0);
    chk({tag, " overflow"},   32'(overflow),   32'h0);
    chk({tag, " underrun"},   32'(underrun),   32'h0);
    chk({tag, " drop_cnt"},   32'(drop_cnt),   32'h0);
  endtask

  logic [31:0] words [4];
  logic [13:0] samp  [8];
  int          lvl, lvl_prev;

  initial begin
    words[0] = 32'h0004_0008; words[1] = 32'h000C_0010;
    words[2] = 32'h0014_0018; words[3] = 32'h001C_0020;
    samp[0] = 14'h002; samp[1] = 14'h001; samp[2] = 14'h004; samp[3] = 14'h003;
    samp[4] = 14'h006; samp[5] = 14'h005; samp[6] = 14'h008; samp[7] = 14'h007;

    rst_n = 1'b0; DATA_DIR = 1'b0; SLCS = 1'b0; SLOE = 1'b0; SLRD = 1'b1;
    DQ = 32'h0; dac_en = 1'b0;
    step(); step();
    chk_all_zero("reset");

    // Latency: strobe sampled at edge 1 -> level 1 at edge 3
    rst_n = 1'b1;
    SLRD  = 1'b0;
    DQ    = words[0];
    step();
    SLRD = 1'b1;
    chk("lat edge1", 32'(fifo_level), 32'd0);
    step();
    chk("lat edge2", 32'(fifo_level), 32'd0);
    step();
    chk("lat edge3", 32'(fifo_level), 32'd1);

    // SLOE high: no capture
    SLOE = 1'b1; SLRD = 1'b0;
    step();
    SLOE = 1'b0; SLRD = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("sloe no capture", 32'(fifo_level), 32'd1);

    // Back-to-back burst of three words
    for (int c = 0; c < 5; c++) begin
      SLRD = (c < 3) ? 1'b0 : 1'b1;
      DQ   = (c >= 2) ? words[c-1] : 32'h0;
      step();
    end
    SLRD = 1'b1;
    chk("burst level", 32'(fifo_level), 32'd4);
    chk("afull low", 32'(fifo_afull), 32'd0);

    // Unpack 4 words into 8 samples, one every 4 cycles
    dac_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("valid k=%0d", k), 32'(dac_valid), 32'((k % 4) == 0));
      if ((k % 4) == 0)
        chk($sformatf("sample %0d", k/4 - 1), 32'(dac_data), 32'(samp[k/4 - 1]));
    end
    chk("drained level", 32'(fifo_level), 32'd0);
    chk("no underrun yet", 32'(underrun), 32'd0);

    // Underrun: one word gives two samples, third tick finds nothing
    dac_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      SLRD = (c < 1) ? 1'b0 : 1'b1;
      DQ   = (c == 2) ? 32'h0024_0028 : 32'h0;
      step();
    end
    chk("one word", 32'(fifo_level), 32'd1);
    dac_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("ur valid k=%0d", k), 32'(dac_valid), 32'((k == 4) || (k == 8)));
      if (k == 4)  chk("ur sample low",  32'(dac_data), 32'h00A);
      if (k == 8)  chk("ur sample high", 32'(dac_data), 32'h009);
      if (k == 11) chk("underrun before", 32'(underrun), 32'd0);
      if (k == 12) begin
        chk("underrun set", 32'(underrun), 32'd1);
        chk("data held",    32'(dac_data), 32'h009);
      end
    end
    dac_en = 1'b0;

    // DATA_DIR flips one cycle after the strobe: nothing written
    SLRD = 1'b0;
    step();
    SLRD = 1'b1; DATA_DIR = 1'b1;
    step();
    DATA_DIR = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("datadir no write", 32'(fifo_level), 32'd0);

    // Overflow: 20 reads into 16 slots, afull when free <= 4
    lvl_prev = 0;
    for (int k = 1; k <= 22; k++) begin
      SLRD = (k <= 20) ? 1'b0 : 1'b1;
      DQ   = 32'(k);
      step();
      lvl = (k < 2) ? 0 : ((k - 2 > 16) ? 16 : k - 2);
      chk($sformatf("ovf level k=%0d", k), 32'(fifo_level), 32'(lvl));
      chk($sformatf("ovf afull k=%0d", k), 32'(fifo_afull), 32'(lvl_prev >= 12));
      chk($sformatf("ovf flag k=%0d", k),  32'(overflow),   32'(k >= 19));
      lvl_prev = lvl;
    end
    chk("drop_cnt", 32'(drop_cnt), 32'd4);

    // Asynchronous reset in the middle of a burst
    SLRD = 1'b0;
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    SLRD = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    chk("post reset level", 32'(fifo_level), 32'd0);

    DQ   = 32'h1234_5678;
    SLRD = 1'b0;
    step();
    SLRD = 1'b1;
    step(); step();
    chk("resume level", 32'(fifo_level), 32'd1);
    chk("resume drop",  32'(drop_cnt),   32'd0);
    dac_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) chk("resume low",  32'(dac_data), 32'h159E);
      if (k == 8) chk("resume high", 32'(dac_data), 32'h048D);
    end
    chk("resume empty", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
